// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one single-port word memory (asynchronous read, synchronous write)
//   between the instruction-fetch requester (I) and the load/store requester
//   (D). One request is latched at a time, the memory is driven for LATENCY
//   cycles, then a one-cycle ready pulse is issued with registered read data.
//
// Parameters
//   LATENCY   memory access cycles per transaction (>= 1)
//
// Ports
//   clk, reset              clock, synchronous active-high reset
//   i_req/i_addr            instruction read request and byte address
//   i_ready/i_rdata         I completion pulse and fetched word
//   d_req/d_write/d_addr/d_wdata  data request, store flag, address, store data
//   d_ready/d_rdata         D completion pulse and loaded word
//   mem_addr/mem_din        byte address and write data to memory
//   mem_read/mem_write      memory read / write enables
//   mem_dout                asynchronous read data from memory
//   busy                    high while a transaction is in BUSY or DONE
module mem_arbiter #(
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ready,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_dout,
  output logic        busy
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic             last_grant_d;  // 1 = D was granted last
  logic             sel_d;         // side owning the current transaction
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;
  logic             lat_write;
  logic [31:0]      lat_addr;
  logic [31:0]      lat_wdata;
  logic             grant_i;
  logic             grant_d;

  assign cnt_zero = (cnt == '0);

  // Round-robin: on a tie the side that did not win last time is granted.
  always_comb begin
    grant_i = i_req && (!d_req || last_grant_d);
    grant_d = d_req && (!i_req || !last_grant_d);
  end

  // ---- state register ----
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // ---- next state and outputs ----
  always_comb begin
    state_nxt = state;
    mem_addr  = '0;
    mem_din   = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    i_ready   = 1'b0;
    d_ready   = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (grant_i || grant_d) state_nxt = BUSY;
      end
      BUSY: begin
        busy      = 1'b1;
        mem_addr  = lat_addr;
        mem_din   = lat_wdata;
        mem_read  = !lat_write;
        // Write only in the final BUSY cycle: exactly one write edge, and a
        // store aborted by reset earlier never touches memory.
        mem_write = lat_write && cnt_zero;
        if (cnt_zero) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        i_ready   = !sel_d;
        d_ready   = sel_d;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---- control registers and read-data capture ----
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_d <= 1'b1;
      sel_d        <= 1'b0;
      cnt          <= '0;
      i_rdata      <= '0;
      d_rdata      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_i || grant_d) begin
            sel_d        <= grant_d;
            last_grant_d <= grant_d;
            cnt          <= CNT_LOAD;
          end
        end
        BUSY: begin
          // Counter stops at zero; it is only reloaded on a new grant.
          if (!cnt_zero) begin
            cnt <= cnt - 1'b1;
          end else if (!lat_write) begin
            if (sel_d) d_rdata <= mem_dout;
            else       i_rdata <= mem_dout;
          end
        end
        default: ;
      endcase
    end
  end

  // ---- latched request (data path, not reset; only read in BUSY) ----
  always_ff @(posedge clk) begin
    if (state == IDLE && (grant_i || grant_d)) begin
      lat_addr  <= grant_d ? d_addr : i_addr;
      lat_wdata <= d_wdata;
      lat_write <= grant_d && d_write;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: a LATENCY=4 instance with a scoreboard and
// table of transactions, plus a LATENCY=1 instance for minimum-latency timing.
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // LATENCY = 4 instance
  logic        i_req, d_req, d_write;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic        i_ready, d_ready, mem_read, mem_write, busy;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_din, mem_dout;
  logic [31:0] mem4 [0:255];

  // LATENCY = 1 instance
  logic        i_req1, d_req1, d_write1;
  logic [31:0] i_addr1, d_addr1, d_wdata1;
  logic        i_ready1, d_ready1, mem_read1, mem_write1, busy1;
  logic [31:0] i_rdata1, d_rdata1, mem_addr1, mem_din1, mem_dout1;
  logic [31:0] mem1 [0:255];

  mem_arbiter #(.LATENCY(4)) dut4 (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
    .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_read(mem_read),
    .mem_write(mem_write), .mem_dout(mem_dout), .busy(busy)
  );

  mem_arbiter #(.LATENCY(1)) dut1 (
    .clk(clk), .reset(reset),
    .i_req(i_req1), .i_addr(i_addr1), .i_ready(i_ready1), .i_rdata(i_rdata1),
    .d_req(d_req1), .d_write(d_write1), .d_addr(d_addr1), .d_wdata(d_wdata1),
    .d_ready(d_ready1), .d_rdata(d_rdata1),
    .mem_addr(mem_addr1), .mem_din(mem_din1), .mem_read(mem_read1),
    .mem_write(mem_write1), .mem_dout(mem_dout1), .busy(busy1)
  );

  // Word memories: asynchronous read, write on the rising edge.
  assign mem_dout  = mem4[mem_addr[9:2]];
  assign mem_dout1 = mem1[mem_addr1[9:2]];
  always @(posedge clk) if (mem_write)  mem4[mem_addr[9:2]]  <= mem_din;
  always @(posedge clk) if (mem_write1) mem1[mem_addr1[9:2]] <= mem_din1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%b exp=%b t=%0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: expected completions in order (side, rdata on that side).
  typedef struct { logic side_d; logic [31:0] data; } sb_t;
  sb_t sbq[$];

  always @(negedge clk) begin
    chkb("ready_overlap", i_ready && d_ready, 1'b0);
    chkb("rw_overlap", mem_read && mem_write, 1'b0);
    chkb("ready_overlap1", i_ready1 && d_ready1, 1'b0);
    if (i_ready || d_ready) begin
      if (sbq.size() == 0) begin
        chkb("unexpected_ready", 1'b1, 1'b0);
      end else begin
        sb_t it;
        it = sbq.pop_front();
        chkb("sb_side", d_ready, it.side_d);
        chk("sb_rdata", it.side_d ? d_rdata : i_rdata, it.data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    i_req = 0; d_req = 0; i_req1 = 0; d_req1 = 0;
    sbq.delete();
    step();
    step();
    @(negedge clk);
    chkb("rst_data4", |{mem_addr, mem_din, i_rdata, d_rdata}, 1'b0);
    chkb("rst_ctl4", |{mem_read, mem_write, i_ready, d_ready, busy}, 1'b0);
    chkb("rst_all1", |{mem_addr1, mem_din1, i_rdata1, d_rdata1, mem_read1,
                       mem_write1, i_ready1, d_ready1, busy1}, 1'b0);
    step();
    reset = 1'b0;
  endtask

  // Single request on the LATENCY=4 instance; waits for its ready (bounded).
  task automatic do_txn(input logic is_d, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp);
    bit got = 0;
    sbq.push_back('{side_d: is_d, data: exp});
    if (is_d) begin
      d_req = 1; d_write = wr; d_addr = addr; d_wdata = wdata;
    end else begin
      i_req = 1; i_addr = addr;
    end
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      got = is_d ? d_ready : i_ready;
    end
    chkb("txn_complete", got, 1'b1);
    step();
    i_req = 0;
    d_req = 0;
  endtask

  typedef struct {
    logic        is_d;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;   // rdata on the granted side at ready
  } vec_t;
  vec_t vt [8];

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    // Stores report the unchanged d_rdata from the preceding load.
    vt[0] = '{1'b0, 1'b0, 32'h040, 32'h0,        32'hDEADBEEF};
    vt[1] = '{1'b1, 1'b0, 32'h044, 32'h0,        32'hA5000011};
    vt[2] = '{1'b1, 1'b1, 32'h100, 32'h55AA55AA, 32'hA5000011};
    vt[3] = '{1'b1, 1'b0, 32'h100, 32'h0,        32'h55AA55AA};
    vt[4] = '{1'b0, 1'b0, 32'h100, 32'h0,        32'h55AA55AA};
    vt[5] = '{1'b1, 1'b1, 32'h008, 32'hCAFEF00D, 32'h55AA55AA};
    vt[6] = '{1'b0, 1'b0, 32'h008, 32'h0,        32'hCAFEF00D};
    vt[7] = '{1'b1, 1'b0, 32'h3FC, 32'h0,        32'hA50000FF};

    for (int k = 0; k < 256; k++) begin
      mem4[k] <= 32'hA5000000 | 32'(k);
      mem1[k] <= 32'hA5000000 | 32'(k);
    end
    mem4[16] <= 32'hDEADBEEF;

    i_addr = 0; d_addr = 0; d_wdata = 0; d_write = 0;
    i_addr1 = 0; d_addr1 = 0; d_wdata1 = 0; d_write1 = 0;
    do_reset();

    // I fetch: read cycles 1-4, ready at 5, idle at 6.
    i_addr = 32'h40; i_req = 1;
    sbq.push_back('{side_d: 1'b0, data: 32'hDEADBEEF});
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      chkb("fetch_mem_read", mem_read, c >= 1 && c <= 4);
      chkb("fetch_i_ready", i_ready, c == 5);
      chkb("fetch_busy", busy, c >= 1 && c <= 5);
      if (c == 2) chk("fetch_mem_addr", mem_addr, 32'h40);
      step();
      if (c == 5) i_req = 0;
    end

    // Tie after reset: I first (ready 5), D sampled at 6 (ready 11).
    do_reset();
    i_addr = 32'h40; i_req = 1;
    d_addr = 32'h100; d_write = 0; d_req = 1;
    sbq.push_back('{side_d: 1'b0, data: 32'hDEADBEEF});
    sbq.push_back('{side_d: 1'b1, data: 32'hA5000040});
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk);
      chkb("tie_i_ready", i_ready, c == 5);
      chkb("tie_d_ready", d_ready, c == 11);
      step();
      if (c == 5)  i_req = 0;
      if (c == 11) d_req = 0;
    end

    // Store: single write in cycle 4, ready at 5, d_rdata unchanged.
    d_addr = 32'h100; d_wdata = 32'h12345678; d_write = 1; d_req = 1;
    sbq.push_back('{side_d: 1'b1, data: 32'hA5000040});
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      chkb("store_mem_write", mem_write, c == 4);
      chkb("store_mem_read", mem_read, 1'b0);
      chkb("store_d_ready", d_ready, c == 5);
      if (c == 4) chk("store_mem_din", mem_din, 32'h12345678);
      step();
      if (c == 5) d_req = 0;
    end
    d_write = 0;
    do_txn(1'b1, 1'b0, 32'h100, 32'h0, 32'h12345678);

    // Continuous contention for 40 cycles: grants at 0,6,...,36 alternate I,D.
    i_addr = 32'h40; d_addr = 32'h44; d_write = 0;
    i_req = 1; d_req = 1;
    for (int g = 0; g < 7; g++) begin
      if (g % 2 == 0) sbq.push_back('{side_d: 1'b0, data: 32'hDEADBEEF});
      else            sbq.push_back('{side_d: 1'b1, data: 32'hA5000011});
    end
    for (int c = 0; c < 40; c++) step();
    i_req = 0; d_req = 0;
    for (int k = 0; k < 20 && sbq.size() > 0; k++) @(negedge clk);
    chk("contention_drained", 32'(sbq.size()), 32'd0);
    step();

    // Reset mid-store: reset in cycle 2, no write, no ready, memory intact.
    d_addr = 32'h8; d_wdata = 32'hBAD0BAD0; d_write = 1; d_req = 1;
    for (int c = 0; c <= 2; c++) begin
      if (c == 2) reset = 1'b1;
      @(negedge clk);
      chkb("abort_mem_write", mem_write, 1'b0);
      step();
    end
    reset = 1'b0; d_req = 0; d_write = 0;
    @(negedge clk);
    chkb("abort_data_zero", |{mem_addr, mem_din, i_rdata, d_rdata}, 1'b0);
    chkb("abort_ctl_zero", |{mem_read, mem_write, i_ready, d_ready, busy}, 1'b0);
    for (int c = 0; c < 8; c++) begin
      step();
      @(negedge clk);
      chkb("abort_no_ready", d_ready, 1'b0);
      chkb("abort_no_write", mem_write, 1'b0);
    end
    chk("abort_mem_intact", mem4[2], 32'hA5000002);
    step();

    // Table of single transactions.
    for (int v = 0; v < 8; v++)
      do_txn(vt[v].is_d, vt[v].wr, vt[v].addr, vt[v].wdata, vt[v].exp);

    // Minimum latency: held fetch gives ready at 2 and 5.
    i_addr1 = 32'h44; i_req1 = 1;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      chkb("min_i_ready", i_ready1, c == 2 || c == 5);
      chkb("min_mem_read", mem_read1, c == 1 || c == 4);
      if (c == 2 || c == 5) chk("min_i_rdata", i_rdata1, 32'hA5000011);
      step();
      if (c == 5) i_req1 = 0;
    end
    d_addr1 = 32'h8; d_wdata1 = 32'h77777777; d_write1 = 1; d_req1 = 1;
    for (int c = 0; c <= 2; c++) begin
      @(negedge clk);
      chkb("min_mem_write", mem_write1, c == 1);
      chkb("min_d_ready", d_ready1, c == 2);
      step();
      if (c == 2) d_req1 = 0;
    end
    chk("min_store_mem", mem1[2], 32'h77777777);

    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
